ks_sub28_pipe: RTL
==================

KS_SUB28_PIPE -- requirements
Module: ks_sub28_pipe

Interface
REQ-001 Parameter WIDTH, default 28, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand pair a/b valid this cycle.
REQ-005 in_ready  output  1  block accepts operands this cycle.
REQ-006 a  input  WIDTH  minuend, unsigned.
REQ-007 b  input  WIDTH  subtrahend, unsigned.
REQ-008 out_valid  output  1  diff/borrow_out valid.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 diff  output  WIDTH  (a - b) mod 2^WIDTH.
REQ-011 borrow_out  output  1  1 when a < b, unsigned.
REQ-012 zero  output  1  1 when diff == 0; present only with KS_SUB_ZERO_FLAG_EN.

Function
REQ-013 diff SHALL equal a + ~b + 1; carry-in fixed at 1; borrow_out SHALL equal the inverted carry out of bit WIDTH-1.
REQ-014 Carries SHALL come from a Kogge-Stone prefix tree: ceil(log2 WIDTH) layers, distances 1,2,4,8,16 for WIDTH=28.
REQ-015 Bits below a layer's distance SHALL use group-generate only, with carry-in as the low operand; higher bits SHALL combine G and P.
REQ-016 Pipeline SHALL have 3 register stages: S1 bitwise p=a^~b, g=a&~b; S2 prefix layers 1-3; S3 layers 4-5 plus sum XOR and borrow.
REQ-017 Latency SHALL be exactly 3 cycles from accepted input to out_valid with no stalls.
REQ-018 A transfer SHALL occur on a rising edge where valid and ready are both 1, on either port.
REQ-019 in_ready SHALL equal (!out_valid || out_ready); all stages advance together when in_ready is 1; a stall SHALL hold every stage.
REQ-020 Throughput SHALL be one result per cycle while out_ready stays 1.
REQ-021 Each stage SHALL carry a valid bit; bubbles SHALL propagate and never raise out_valid.
REQ-022 diff, borrow_out and zero SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 in_ready SHALL not depend on in_valid.

Reset
REQ-024 On rst_n low, all stage valid bits, out_valid, diff, borrow_out and zero SHALL clear to 0 immediately.
REQ-025 in_ready SHALL read 1 during and after reset.
REQ-026 Reset mid-operation SHALL discard all in-flight operands; no result from before reset SHALL appear.

Configuration
REQ-027 Macro KS_SUB_ZERO_FLAG_EN defined: zero port and its S3 register SHALL exist; zero = ~|diff, registered with diff.
REQ-028 Macro undefined: zero port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package ks_pkg SHALL hold WIDTH default 28, LATENCY = 3, and the prefix-distance constants.
REQ-030 Sub-module ks_prefix_layer SHALL implement one prefix layer, parameterised by distance, instantiated five times.
REQ-031 All pipeline registers SHALL be in ks_sub28_pipe; ks_prefix_layer SHALL be purely combinational.

Verification
REQ-032 a=0x0000005, b=0x0000003, out_ready=1 -> 3 cycles later diff=0x0000002, borrow_out=0, zero=0.
REQ-033 a=0x0000000, b=0x0000001 -> diff=0xFFFFFFF, borrow_out=1 (full carry-chain ripple).
REQ-034 a=b=0xABCDEF1 -> diff=0, borrow_out=0, zero=1 when the macro is defined.
REQ-035 Back-to-back inputs 3 cycles, out_ready=0 from cycle 3 for 4 cycles -> in_ready=0 during hold, outputs stable, no loss; in-order results after release.
REQ-036 rst_n pulsed low with 2 operands in flight -> out_valid=0 at once; no stale output after reset release.
REQ-037 10^5 random a/b with random in_valid/out_ready -> every diff/borrow matches the reference model, in order.

Source files
------------

// File: rtl/ks_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ks_pkg
//  Description : Shared constants for the pipelined Kogge-Stone subtractor:
//                default operand width, pipeline latency and the prefix
//                layer distances, plus helpers to derive the layer count.
//  Revision    : 1.0 - initial release
// ============================================================================
package ks_pkg;

    localparam int WIDTH_DEF      = 28;
    localparam int LATENCY        = 3;

    // Prefix distances for the default 28-bit build: ceil(log2(28)) = 5 layers
    localparam int NUM_LAYERS_DEF = 5;
    localparam int DIST_L0        = 1;
    localparam int DIST_L1        = 2;
    localparam int DIST_L2        = 4;
    localparam int DIST_L3        = 8;
    localparam int DIST_L4        = 16;

    // Number of prefix layers evaluated ahead of the second pipeline register
    localparam int S2_LAYERS      = 3;

    // Distance spanned by prefix layer 'layer' (layer 0 combines neighbours)
    function automatic int ks_dist(input int layer);
        return 1 << layer;
    endfunction

    // Prefix layers required to cover a 'w'-bit operand
    function automatic int ks_num_layers(input int w);
        return $clog2(w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ks_prefix_layer.sv
`default_nettype none
// ============================================================================
//  Module      : ks_prefix_layer
//  Description : One purely combinational Kogge-Stone prefix layer. Bits at or
//                above DIST merge their (G,P) pair with the pair DIST places
//                lower; bits below DIST have no lower partner, so they absorb
//                the carry-in instead and their group propagate is cleared
//                because the group already reaches the carry-in.
//  Revision    : 1.0 - initial release
// ============================================================================
module ks_prefix_layer #(
    parameter int WIDTH = 28,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] i_g,
    input  logic [WIDTH-1:0] i_p,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_g,
    output logic [WIDTH-1:0] o_p
);

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            if (i < DIST) begin : g_low
                // Lowest bits: combine with the subtractor carry-in only
                assign o_g[i] = i_g[i] | (i_p[i] & i_cin);
                assign o_p[i] = 1'b0;
            end else begin : g_high
                // Regular black cell: merge with the group DIST bits lower
                assign o_g[i] = i_g[i] | (i_p[i] & i_g[i-DIST]);
                assign o_p[i] = i_p[i] & i_p[i-DIST];
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ks_sub28_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ks_sub28_pipe
//  Description : Three-stage pipelined unsigned subtractor computing
//                diff = a + ~b + 1 with a Kogge-Stone carry tree and a
//                valid/ready handshake on both ports.
//                  S1: bitwise p = a ^ ~b, g = a & ~b
//                  S2: prefix layers 1..3
//                  S3: remaining prefix layers, sum XOR, borrow (and zero)
//                Optional feature macro: KS_SUB_ZERO_FLAG_EN adds the
//                registered 'zero' output (diff == 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module ks_sub28_pipe
    import ks_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef KS_SUB_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int NUM_LAYERS = ks_num_layers(WIDTH);
    localparam int NL2        = (NUM_LAYERS < S2_LAYERS) ? NUM_LAYERS : S2_LAYERS;
    localparam int NL3        = NUM_LAYERS - NL2;

    // Stage valid bits
    logic             r_v1;
    logic             r_v2;
    logic             r_v3;

    // Stage 1: bitwise propagate/generate (p also serves as the sum half-term)
    logic [WIDTH-1:0] r_s1_p;
    logic [WIDTH-1:0] r_s1_g;

    // Stage 2: partial prefix results plus the untouched bitwise propagate
    logic [WIDTH-1:0] r_s2_g;
    logic [WIDTH-1:0] r_s2_p;
    logic [WIDTH-1:0] r_s2_praw;

    // Stage 3: result registers
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
`ifdef KS_SUB_ZERO_FLAG_EN
    logic             r_zero;
`endif

    logic             w_in_ready;
    logic [WIDTH-1:0] w_g2 [0:NL2];
    logic [WIDTH-1:0] w_p2 [0:NL2];
    logic [WIDTH-1:0] w_g3 [0:NL3];
    logic [WIDTH-1:0] w_p3 [0:NL3];
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_diff;
    logic             w_borrow;

    // The whole pipeline moves only when the output slot is free or draining
    assign w_in_ready = !r_v3 || out_ready;

    // Prefix layers between S1 and S2
    assign w_g2[0] = r_s1_g;
    assign w_p2[0] = r_s1_p;

    genvar k;
    generate
        for (k = 0; k < NL2; k++) begin : g_s2_layer
            ks_prefix_layer #(
                .WIDTH (WIDTH),
                .DIST  (ks_dist(k))
            ) u_layer (
                .i_g   (w_g2[k]),
                .i_p   (w_p2[k]),
                .i_cin (1'b1),
                .o_g   (w_g2[k+1]),
                .o_p   (w_p2[k+1])
            );
        end
    endgenerate

    // Prefix layers between S2 and S3
    assign w_g3[0] = r_s2_g;
    assign w_p3[0] = r_s2_p;

    generate
        for (k = 0; k < NL3; k++) begin : g_s3_layer
            ks_prefix_layer #(
                .WIDTH (WIDTH),
                .DIST  (ks_dist(NL2 + k))
            ) u_layer (
                .i_g   (w_g3[k]),
                .i_p   (w_p3[k]),
                .i_cin (1'b1),
                .o_g   (w_g3[k+1]),
                .o_p   (w_p3[k+1])
            );
        end
    endgenerate

    // Carry into bit i is the full group generate of bits i-1..0 (with cin=1)
    assign w_carry  = {w_g3[NL3][WIDTH-2:0], 1'b1};
    assign w_diff   = r_s2_praw ^ w_carry;
    assign w_borrow = ~w_g3[NL3][WIDTH-1];

    // Stage 1 register: capture operands as bitwise p/g
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_s1_p <= '0;
            r_s1_g <= '0;
        end else if (w_in_ready) begin
            r_v1   <= in_valid;
            r_s1_p <= a ^ ~b;
            r_s1_g <= a & ~b;
        end
    end

    // Stage 2 register: partial prefix tree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2      <= 1'b0;
            r_s2_g    <= '0;
            r_s2_p    <= '0;
            r_s2_praw <= '0;
        end else if (w_in_ready) begin
            r_v2      <= r_v1;
            r_s2_g    <= w_g2[NL2];
            r_s2_p    <= w_p2[NL2];
            r_s2_praw <= r_s1_p;
        end
    end

    // Stage 3 register: final difference, borrow and optional zero flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3     <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
`ifdef KS_SUB_ZERO_FLAG_EN
            r_zero   <= 1'b0;
`endif
        end else if (w_in_ready) begin
            r_v3     <= r_v2;
            r_diff   <= w_diff;
            r_borrow <= w_borrow;
`ifdef KS_SUB_ZERO_FLAG_EN
            r_zero   <= ~|w_diff;
`endif
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_v3;
    assign diff       = r_diff;
    assign borrow_out = r_borrow;
`ifdef KS_SUB_ZERO_FLAG_EN
    assign zero       = r_zero;
`endif

endmodule
`default_nettype wire
